// File: rtl/mips_pkg.sv
// Shared pipeline definitions: fetch vectors, word-alignment mask and the
// next-PC source encoding used by the PC generation stage.
package mips_pkg;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_0080;
    localparam logic [31:0] WORD_ALIGN       = 32'hFFFF_FFFC;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_SEQ,
        SEL_BR,
        SEL_JMP,
        SEL_PEND,
        SEL_EXC
    } npc_sel_t;

    function automatic logic misaligned(input logic [31:0] addr);
        return |addr[1:0];
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Control and address bundle between the pipeline (master) and the PC
// generation stage (slave).
interface pc_gen_if;

    logic        Stall;
    logic        Flush;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        Exception;
    logic [31:0] IAddr;
    logic [31:0] PC;
    logic [31:0] FetchedPC;
    logic        RedirPending;
    logic        AlignErr;

    modport master (
        output Stall, Flush, BranchTaken, BranchTarget, Jump, JumpTarget, Exception,
        input  IAddr, PC, FetchedPC, RedirPending, AlignErr
    );

    modport slave (
        input  Stall, Flush, BranchTaken, BranchTarget, Jump, JumpTarget, Exception,
        output IAddr, PC, FetchedPC, RedirPending, AlignErr
    );

endinterface

// File: rtl/pc_redirect_buf.sv
// Single-entry holding register for a redirect target that arrived while the
// pipeline was stalled; clear beats load beats consume.
module pc_redirect_buf (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        i_load,
    input  logic        i_clear,
    input  logic        i_consume,
    input  logic [31:0] i_target,
    output logic [31:0] o_target,
    output logic        o_valid
);

    logic [31:0] r_target;
    logic        r_valid;

    always_ff @(posedge Clk) begin
        if (Reset || i_clear) begin
            r_target <= '0;
            r_valid  <= 1'b0;
        end else if (i_load) begin
            // A later redirect in the same stall simply replaces the earlier one.
            r_target <= i_target;
            r_valid  <= 1'b1;
        end else if (i_consume) begin
            r_valid  <= 1'b0;
        end
    end

    assign o_target = r_target;
    assign o_valid  = r_valid;

endmodule

// File: rtl/pc_gen.sv
// Program-counter generation: priority next-PC select, fetch PC register and
// the PC of the word currently handed to decode (one cycle behind PC).
module pc_gen
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
    input logic     Clk,
    input logic     Reset,
    pc_gen_if.slave bus
);

    logic [31:0] r_pc;
    logic [31:0] r_fetched_pc;
    logic        r_align_err;

    npc_sel_t    w_sel;
    logic [31:0] w_pc_next;
    logic [31:0] w_fetched_next;
    logic        w_redirect;
    logic [31:0] w_redir_target;
    logic        w_pend_valid;
    logic [31:0] w_pend_target;
    logic        w_buf_load;
    logic        w_buf_consume;
    logic        w_align_next;

    assign w_redirect     = bus.BranchTaken | bus.Jump;
    assign w_redir_target = bus.BranchTaken ? bus.BranchTarget : bus.JumpTarget;

    always_comb begin
        w_sel = SEL_SEQ;
        if (bus.Exception)
            w_sel = SEL_EXC;
        else if (bus.Flush)
            w_sel = SEL_HOLD;
        else if (bus.BranchTaken && !bus.Stall)
            w_sel = SEL_BR;
        else if (bus.Jump && !bus.Stall)
            w_sel = SEL_JMP;
        else if (w_pend_valid && !bus.Stall)
            w_sel = SEL_PEND;
        else if (bus.Stall)
            w_sel = SEL_HOLD;
    end

    // The delay-slot word is already in flight, so redirects keep FetchedPC<=PC.
    always_comb begin
        w_pc_next      = r_pc;
        w_fetched_next = r_fetched_pc;
        case (w_sel)
            SEL_EXC: begin
                w_pc_next      = EXC_VECTOR;
                w_fetched_next = '0;
            end
            SEL_BR: begin
                w_pc_next      = bus.BranchTarget & WORD_ALIGN;
                w_fetched_next = r_pc;
            end
            SEL_JMP: begin
                w_pc_next      = bus.JumpTarget & WORD_ALIGN;
                w_fetched_next = r_pc;
            end
            SEL_PEND: begin
                w_pc_next      = w_pend_target & WORD_ALIGN;
                w_fetched_next = r_pc;
            end
            SEL_SEQ: begin
                w_pc_next      = r_pc + 32'd4;
                w_fetched_next = r_pc;
            end
            SEL_HOLD: begin
                if (bus.Flush) begin
                    w_pc_next      = RESET_VECTOR;
                    w_fetched_next = '0;
                end
            end
            default: begin
                w_pc_next      = r_pc;
                w_fetched_next = r_fetched_pc;
            end
        endcase
    end

    // A redirect is accepted either by steering the PC or by being buffered.
    assign w_buf_load    = !bus.Exception && !bus.Flush && bus.Stall && w_redirect;
    assign w_buf_consume = (w_sel == SEL_PEND) || (w_sel == SEL_BR) || (w_sel == SEL_JMP);
    assign w_align_next  = !bus.Exception && !bus.Flush && w_redirect && misaligned(w_redir_target);

    pc_redirect_buf u_redirect_buf (
        .Clk       (Clk),
        .Reset     (Reset),
        .i_load    (w_buf_load),
        .i_clear   (bus.Exception),
        .i_consume (w_buf_consume),
        .i_target  (w_redir_target),
        .o_target  (w_pend_target),
        .o_valid   (w_pend_valid)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pc         <= RESET_VECTOR;
            r_fetched_pc <= '0;
            r_align_err  <= 1'b0;
        end else begin
            r_pc         <= w_pc_next;
            r_fetched_pc <= w_fetched_next;
            r_align_err  <= w_align_next;
        end
    end

    assign bus.IAddr        = r_pc;
    assign bus.PC           = r_pc;
    assign bus.FetchedPC    = r_fetched_pc;
    assign bus.RedirPending = w_pend_valid;
    assign bus.AlignErr     = r_align_err;

endmodule

// File: tb/tb_pc_gen.sv
// Scenario bench for pc_gen: each cycle's expected outputs are queued with the
// stimulus and checked against the sampled DUT outputs in each scenario task.
module tb_pc_gen;

    typedef struct packed {
        logic [31:0] iaddr;
        logic [31:0] pc;
        logic [31:0] fpc;
        logic        pend;
        logic        al;
    } obs_t;

    logic Clk;
    logic Reset;
    pc_gen_if bus ();

    obs_t exp_q[$];
    obs_t obs_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    pc_gen u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Drives one cycle of stimulus, queues its expectation, samples after the edge.
    task automatic step(input logic rst, input logic stall, input logic flush, input logic exc,
                        input logic br, input logic [31:0] bt, input logic jmp, input logic [31:0] jt,
                        input logic [31:0] e_pc, input logic [31:0] e_fpc,
                        input logic e_pend, input logic e_al);
        obs_t e;
        obs_t o;
        Reset            = rst;
        bus.Stall        = stall;
        bus.Flush        = flush;
        bus.Exception    = exc;
        bus.BranchTaken  = br;
        bus.BranchTarget = bt;
        bus.Jump         = jmp;
        bus.JumpTarget   = jt;
        e = '{iaddr: e_pc, pc: e_pc, fpc: e_fpc, pend: e_pend, al: e_al};
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
        o = '{iaddr: bus.IAddr, pc: bus.PC, fpc: bus.FetchedPC, pend: bus.RedirPending, al: bus.AlignErr};
        obs_q.push_back(o);
    endtask

    task automatic test_reset;
        obs_t e, o;
        step(1, 0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 32'h4, 32'h0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 32'h8, 32'h4, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 32'hC, 32'h8, 0, 0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_mis++;
                $display("FAIL reset[%0d]: got iaddr=%h pc=%h fpc=%h pend=%b al=%b, expected iaddr=%h pc=%h fpc=%h pend=%b al=%b",
                         i, o.iaddr, o.pc, o.fpc, o.pend, o.al, e.iaddr, e.pc, e.fpc, e.pend, e.al);
            end
        end
    endtask

    task automatic test_branch;
        obs_t e, o;
        for (int a = 32'h10; a <= 32'h20; a += 4)
            step(0, 0, 0, 0, 0, 0, 0, 0, a, a - 4, 0, 0);
        step(0, 0, 0, 0, 1, 32'h100, 0, 0, 32'h100, 32'h20, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 32'h104, 32'h100, 0, 0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_mis++;
                $display("FAIL branch[%0d]: got iaddr=%h pc=%h fpc=%h pend=%b al=%b, expected iaddr=%h pc=%h fpc=%h pend=%b al=%b",
                         i, o.iaddr, o.pc, o.fpc, o.pend, o.al, e.iaddr, e.pc, e.fpc, e.pend, e.al);
            end
        end
    endtask

    task automatic test_stall_redirect;
        obs_t e, o;
        step(0, 1, 0, 0, 0, 0, 0, 0,       32'h104, 32'h100, 0, 0);
        step(0, 1, 0, 0, 0, 0, 1, 32'h400, 32'h104, 32'h100, 1, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0,       32'h104, 32'h100, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0,       32'h400, 32'h104, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0,       32'h404, 32'h400, 0, 0);
        // second redirect in the same stall replaces the first
        step(0, 1, 0, 0, 0, 0, 1, 32'h500, 32'h404, 32'h400, 1, 0);
        step(0, 1, 0, 0, 1, 32'h600, 0, 0, 32'h404, 32'h400, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0,       32'h600, 32'h404, 0, 0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_mis++;
                $display("FAIL stall_redirect[%0d]: got iaddr=%h pc=%h fpc=%h pend=%b al=%b, expected iaddr=%h pc=%h fpc=%h pend=%b al=%b",
                         i, o.iaddr, o.pc, o.fpc, o.pend, o.al, e.iaddr, e.pc, e.fpc, e.pend, e.al);
            end
        end
    endtask

    task automatic test_simultaneous;
        obs_t e, o;
        step(0, 0, 0, 0, 1, 32'h200, 1, 32'h300, 32'h200, 32'h600, 0, 0);
        step(0, 0, 0, 1, 1, 32'h700, 0, 0,       32'h80,  32'h0,   0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0,             32'h84,  32'h80,  0, 0);
        // exception while a redirect is buffered discards it
        step(0, 1, 0, 0, 0, 0, 1, 32'h900,       32'h84,  32'h80,  1, 0);
        step(0, 1, 0, 1, 0, 0, 0, 0,             32'h80,  32'h0,   0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0,             32'h84,  32'h80,  0, 0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_mis++;
                $display("FAIL simultaneous[%0d]: got iaddr=%h pc=%h fpc=%h pend=%b al=%b, expected iaddr=%h pc=%h fpc=%h pend=%b al=%b",
                         i, o.iaddr, o.pc, o.fpc, o.pend, o.al, e.iaddr, e.pc, e.fpc, e.pend, e.al);
            end
        end
    endtask

    task automatic test_boundary;
        obs_t e, o;
        step(0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'h84,         0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0,             32'hFFFF_FFFC, 32'hFFFF_FFF8, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0,             32'h0,         32'hFFFF_FFFC, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0,             32'h4,         32'h0,         0, 0);
        step(0, 0, 0, 0, 1, 32'h103, 0, 0,       32'h100,       32'h4,         0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0,             32'h104,       32'h100,       0, 0);
        // misaligned target buffered in a stall flags once, when buffered
        step(0, 1, 0, 0, 0, 0, 1, 32'h202,       32'h104,       32'h100,       1, 1);
        step(0, 1, 0, 0, 0, 0, 0, 0,             32'h104,       32'h100,       1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0,             32'h200,       32'h104,       0, 0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_mis++;
                $display("FAIL boundary[%0d]: got iaddr=%h pc=%h fpc=%h pend=%b al=%b, expected iaddr=%h pc=%h fpc=%h pend=%b al=%b",
                         i, o.iaddr, o.pc, o.fpc, o.pend, o.al, e.iaddr, e.pc, e.fpc, e.pend, e.al);
            end
        end
    endtask

    task automatic test_reset_pending;
        obs_t e, o;
        step(0, 1, 0, 0, 0, 0, 1, 32'h800, 32'h200, 32'h104, 1, 0);
        step(1, 1, 1, 0, 0, 0, 0, 0,       32'h0,   32'h0,   0, 0);
        // redirects during flush are neither taken nor buffered
        step(0, 0, 1, 0, 1, 32'h300, 0, 0, 32'h0,   32'h0,   0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0,       32'h4,   32'h0,   0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0,       32'h8,   32'h4,   0, 0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_mis++;
                $display("FAIL reset_pending[%0d]: got iaddr=%h pc=%h fpc=%h pend=%b al=%b, expected iaddr=%h pc=%h fpc=%h pend=%b al=%b",
                         i, o.iaddr, o.pc, o.fpc, o.pend, o.al, e.iaddr, e.pc, e.fpc, e.pend, e.al);
            end
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_stall_redirect();
        test_simultaneous();
        test_boundary();
        test_reset_pending();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Program-counter generation stage, directly upstream of the fetch stage. Holds the architectural fetch PC, drives the instruction-RAM address and selects the next PC from sequential, branch, jump and exception sources. Holds the PC under pipeline stall and post-reset flush, and buffers redirects that arrive while stalled. Registers the PC of each instruction handed to decode so it stays aligned with the fetched instruction word.

## Interface

**Parameters**
- RESET_VECTOR, 32'h0000_0000: first fetch address after reset/flush.
- EXC_VECTOR, 32'h0000_0080: exception entry address.

**Ports**
- Clk  in  1  clock; PC updates on posedge.
- Reset  in  1  synchronous, active-high.
- Stall  in  1  hazard stall from decode; same signal the fetch stage uses.
- Flush  in  1  post-reset flush flag produced by the fetch stage.
- BranchTaken  in  1  resolved taken branch, one-cycle pulse.
- BranchTarget  in  32  branch destination.
- Jump  in  1  J/JAL/JR redirect, one-cycle pulse.
- JumpTarget  in  32  jump destination.
- Exception  in  1  exception request, one-cycle pulse.
- IAddr  out  32  instruction-RAM address; equals PC (registered, no combinational path from inputs).
- PC  out  32  current fetch PC.
- FetchedPC  out  32  PC of the word the fetch stage presents to decode this cycle.
- RedirPending  out  1  a buffered redirect is waiting for the stall to clear.
- AlignErr  out  1  one-cycle pulse: an accepted redirect target had bits [1:0] ≠ 0.

## Operation

- **Next-PC priority**, evaluated at each posedge:
  1. Reset
  2. Exception
  3. Flush
  4. New redirect: BranchTaken over Jump
  5. Pending redirect
  6. Stall
  7. Sequential
- **Reset:** PC=RESET_VECTOR, FetchedPC=0, pending register cleared, RedirPending=0, AlignErr=0.
- **Exception:** PC←EXC_VECTOR regardless of Stall/Flush. Clears the pending register. FetchedPC←0 (bubble).
- **Flush=1:** PC held at RESET_VECTOR, FetchedPC←0. Redirect inputs ignored and not buffered.
- **Redirect, Stall=0:** PC←target&~3, FetchedPC←PC. AlignErr←|target[1:0].
- **Redirect, Stall=1:** target stored in the pending register, RedirPending←1. PC and FetchedPC held.
  - A second redirect during the same stall overwrites the pending target.
- **Pending, Stall=0, no new redirect:** PC←pending target, FetchedPC←PC, RedirPending←0.
- **Stall=1, no redirect:** PC and FetchedPC held.
- **Sequential:** PC←PC+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0. FetchedPC←PC.
- **Branch delay slot:** the word at branch PC+4 is already fetched when the redirect arrives and is never squashed. No bubble is inserted.
- **AlignErr:** low in every cycle without an accepted redirect. A pending target applied later raises AlignErr in the cycle it is buffered, not again when applied.

## Timing

- IAddr is valid from posedge. The instruction RAM reads during the low phase, and the fetch stage latches the word on negedge and presents it at the next posedge. FetchedPC is therefore one cycle behind PC.
- Flush and Stall are sampled at the same posedge the fetch stage samples them. The first posedge with Flush=0 and Stall=0 sets FetchedPC=RESET_VECTOR and PC=RESET_VECTOR+4.
- Redirect latency: the target appears on IAddr the cycle after the accepted pulse. With a stall, it appears the cycle after the first posedge with Stall=0.
- Reset during a pending redirect discards it. Reset during Flush restarts the flush sequence unchanged.

## Structure

- **Shared package `mips_pkg`:**
  - RESET_VECTOR_DEF and EXC_VECTOR_DEF constants.
  - Next-PC select enum `npc_sel_t` {SEL_HOLD, SEL_SEQ, SEL_BR, SEL_JMP, SEL_PEND, SEL_EXC}.
  - WORD_ALIGN mask.
- **Sub-module `pc_redirect_buf`:** the pending-target register with valid bit. Ports: load, clear, consume, target in/out.
- **Top level:** priority select, PC and FetchedPC registers.

## Test plan

- **Reset then flush release:** Reset 1 cycle, Flush held 6 cycles → IAddr=0 throughout; first unflushed cycle FetchedPC=0x0, PC=0x4; then 0x8, 0xC.
- **Taken branch:** BranchTaken pulse with BranchTarget=0x100 while PC=0x20 → next PC=0x100; FetchedPC sequence 0x1C, 0x20, 0x100 (0x20 is the delay slot, kept).
- **Redirect during stall:** Stall=1 for 3 cycles, Jump pulse with JumpTarget=0x400 in the 2nd → RedirPending=1 and PC held; first cycle with Stall=0 → PC=0x400, RedirPending=0.
- **Simultaneous sources:**
  - BranchTaken=0x200 and Jump=0x300 together → PC=0x200.
  - Exception with BranchTaken → PC=0x80, FetchedPC=0.
- **Boundary:**
  - PC=0xFFFF_FFFC sequential → 0x0.
  - BranchTarget=0x103 → PC=0x100, AlignErr pulses 1 cycle.
  - Reset with RedirPending=1 → pending cleared, PC=RESET_VECTOR.
